// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, taken-branch redirect with a flush bubble window,
// and an optional misaligned-target trap compiled in when PC_SEQ_ALIGN_CHECK_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [31:0] PC_branch,
  input  logic        trap_ack,
  output logic [31:0] PC_out,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign_trap,
  output logic [31:0] trap_pc
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t     state;
  logic [2:0] count;
  logic       taken;
  logic       to_trap;

  assign taken = branch_valid & branch_taken;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic        trap_q;
  logic [31:0] trap_pc_q;

  assign to_trap = taken & (|PC_branch[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else if (state == RUN && fetch_valid && to_trap) begin
      trap_q    <= 1'b1;
      trap_pc_q <= PC_branch;
    end else if (state == TRAP && trap_ack) begin
      trap_q    <= 1'b0;
    end
  end

  assign misalign_trap = trap_q;
  assign trap_pc       = trap_pc_q;
`else
  assign to_trap       = 1'b0;
  assign misalign_trap = 1'b0;
  assign trap_pc       = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      count       <= '0;
      PC_out      <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // RUN with fetch_valid low only occurs on the first edge after reset:
          // present RESET_PC as valid before advancing.
          if (!fetch_valid) begin
            fetch_valid <= 1'b1;
          end else if (to_trap) begin
            state       <= TRAP;
            fetch_valid <= 1'b0;
            flush       <= 1'b1;
          end else if (taken) begin
            PC_out      <= PC_branch;
            count       <= FLUSH_LOAD;
            state       <= FLUSH;
            fetch_valid <= 1'b0;
            flush       <= 1'b1;
          end else if (!stall) begin
            PC_out <= PC_out + 32'd4;
          end
        end
        FLUSH: begin
          count <= count - 3'd1;
          if (count <= 3'd1) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            flush       <= 1'b0;
          end
        end
        TRAP: begin
          if (trap_ack) begin
            PC_out <= RESET_PC;
            count  <= FLUSH_LOAD;
            state  <= FLUSH;
          end
        end
        default: begin
          state       <= RUN;
          fetch_valid <= 1'b0;
          flush       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against
// a behavioural model; adapts to PC_SEQ_ALIGN_CHECK_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FC     = 2;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] PC_branch = '0;
  logic        trap_ack = 1'b0;
  logic [31:0] PC_out;
  logic        fetch_valid;
  logic        flush;
  logic        misalign_trap;
  logic [31:0] trap_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_primed;
  int          m_bubbles;
  bit          m_trap;
  logic [31:0] m_tpc;

  pc_sequencer #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .PC_branch    (PC_branch),
    .trap_ack     (trap_ack),
    .PC_out       (PC_out),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .misalign_trap(misalign_trap),
    .trap_pc      (trap_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    PC_out,                  m_pc);
    chk({tag, ".fv"},    32'(fetch_valid),        32'(m_primed && m_bubbles == 0 && !m_trap));
    chk({tag, ".flush"}, 32'(flush),              32'(m_bubbles > 0 || m_trap));
    chk({tag, ".mt"},    32'(misalign_trap),      32'(m_trap));
    chk({tag, ".tpc"},   trap_pc,                 m_tpc);
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_primed  = 1'b0;
    m_bubbles = 0;
    m_trap    = 1'b0;
    m_tpc     = '0;
  endtask

  task automatic model_step();
    if (!m_primed) begin
      m_primed = 1'b1;
    end else if (m_trap) begin
      if (trap_ack) begin
        m_trap    = 1'b0;
        m_pc      = RST_PC;
        m_bubbles = FC;
      end
    end else if (m_bubbles > 0) begin
      m_bubbles--;
    end else if (branch_valid && branch_taken) begin
      if (CHK && PC_branch % 4 != 0) begin
        m_trap = 1'b1;
        m_tpc  = PC_branch;
      end else begin
        m_pc      = PC_branch;
        m_bubbles = FC;
      end
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cyc(input bit s, input bit bv, input bit bt, input logic [31:0] t,
                     input bit a, input string tag);
    stall        = s;
    branch_valid = bv;
    branch_taken = bt;
    PC_branch    = t;
    trap_ack     = a;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    chk("reset_pc", PC_out, 32'h0);

    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, '0, 0, "seq");
      chk("seq_pc", PC_out, 32'(i * 4));
      chk("seq_fv", 32'(fetch_valid), 32'd1);
    end
    cyc(0, 0, 0, '0, 0, "to_0x10");
    chk("at_0x10", PC_out, 32'h10);

    cyc(1, 1, 1, 32'h100, 0, "br_stall");
    chk("br_pc", PC_out, 32'h100);
    chk("br_flush", 32'(flush), 32'd1);
    cyc(0, 1, 1, 32'h300, 0, "br_flush2");
    chk("br_flush2_fv", 32'(fetch_valid), 32'd0);
    cyc(0, 0, 0, '0, 0, "br_run");
    chk("br_run_flush", 32'(flush), 32'd0);
    cyc(0, 0, 0, '0, 0, "br_next");
    chk("br_next_pc", PC_out, 32'h104);

    cyc(0, 1, 0, 32'h500, 1, "not_taken");
    chk("not_taken_pc", PC_out, 32'h108);

    cyc(0, 1, 1, 32'hFFFF_FFFC, 0, "wrap_br");
    cyc(0, 0, 0, '0, 0, "wrap_f");
    cyc(0, 0, 0, '0, 0, "wrap_run");
    chk("wrap_top", PC_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0, '0, 0, "wrap");
    chk("wrap_pc", PC_out, 32'h0);

    cyc(0, 1, 1, 32'h102, 0, "mis_br");
    if (CHK) begin
      chk("mis_mt", 32'(misalign_trap), 32'd1);
      chk("mis_tpc", trap_pc, 32'h102);
      chk("mis_pc_held", PC_out, 32'h0);
      cyc(0, 1, 1, 32'h400, 0, "trap_hold1");
      cyc(1, 0, 0, '0, 0, "trap_hold2");
      chk("trap_pc_held", PC_out, 32'h0);
      cyc(0, 0, 0, '0, 1, "trap_ack");
      chk("ack_pc", PC_out, RST_PC);
      chk("ack_mt", 32'(misalign_trap), 32'd0);
      chk("ack_tpc_kept", trap_pc, 32'h102);
      cyc(0, 0, 0, '0, 0, "ack_f2");
      chk("ack_f2_flush", 32'(flush), 32'd1);
      cyc(0, 0, 0, '0, 0, "ack_run");
      chk("ack_run_fv", 32'(fetch_valid), 32'd1);
    end else begin
      chk("nochk_pc", PC_out, 32'h102);
      chk("nochk_mt", 32'(misalign_trap), 32'd0);
      cyc(0, 0, 0, '0, 0, "nochk_f2");
      cyc(0, 0, 0, '0, 0, "nochk_run");
    end

    cyc(0, 1, 1, 32'h200, 0, "rst_mid_br");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    chk("rst_mid_flush", 32'(flush), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, '0, 0, "restart0");
    chk("restart0_pc", PC_out, RST_PC);
    cyc(0, 0, 0, '0, 0, "restart1");
    chk("restart1_pc", PC_out, RST_PC + 32'd4);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        cyc(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 1)), t, bit'($urandom_range(0, 3) == 0), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset and on trap acknowledge.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7: number of bubble cycles after a redirect.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the current PC this cycle.
REQ-006 The block SHALL have port branch_valid, input, 1 bit: a branch resolution is presented this cycle.
REQ-007 The block SHALL have port branch_taken, input, 1 bit: the resolved branch is taken; qualified by branch_valid.
REQ-008 The block SHALL have port PC_branch, input, 32 bits: branch target, PC plus sign-extended immediate, from the branch adder.
REQ-009 The block SHALL have port trap_ack, input, 1 bit: trap handler acknowledge.
REQ-010 The block SHALL have port PC_out, output, 32 bits: registered fetch address.
REQ-011 The block SHALL have port fetch_valid, output, 1 bit: PC_out is a valid fetch address this cycle.
REQ-012 The block SHALL have port flush, output, 1 bit: kill younger in-flight instructions.
REQ-013 The block SHALL have port misalign_trap, output, 1 bit: misaligned branch target trap pending.
REQ-014 The block SHALL have port trap_pc, output, 32 bits: offending branch target captured at trap entry.

Function
REQ-015 The FSM SHALL have three states, RUN, FLUSH and TRAP, and a 3-bit flush down-counter.
REQ-016 A taken redirect SHALL be branch_valid=1 and branch_taken=1 while in RUN.
REQ-017 In RUN with a taken redirect and an aligned target: PC_out<=PC_branch, counter<=FLUSH_CYCLES, state<=FLUSH.
REQ-018 In RUN, a taken redirect SHALL have priority over stall.
REQ-019 In RUN, otherwise, stall=1 SHALL hold PC_out, and stall=0 SHALL update PC_out<=PC_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 branch_valid=1 with branch_taken=0 SHALL behave as no branch.
REQ-021 In RUN, fetch_valid SHALL be 1 and flush SHALL be 0.
REQ-022 In FLUSH: flush=1, fetch_valid=0, PC_out held, branch_valid ignored, and the counter decrements every cycle regardless of stall.
REQ-023 When the counter reaches 1 in FLUSH, the next state SHALL be RUN, so flush is high for exactly FLUSH_CYCLES cycles.
REQ-024 A target is misaligned when PC_branch[1:0]!=0.
REQ-025 When enabled, a taken misaligned redirect SHALL cause: state<=TRAP, trap_pc<=PC_branch, misalign_trap<=1, PC_out unchanged.
REQ-026 In TRAP: fetch_valid=0, flush=1, PC_out held, and branch and stall inputs ignored.
REQ-027 In TRAP with trap_ack=1: PC_out<=RESET_PC, misalign_trap<=0, counter<=FLUSH_CYCLES, state<=FLUSH; trap_pc retains its value.
REQ-028 trap_ack outside TRAP SHALL be ignored.

Reset
REQ-029 While rst=1, asynchronously: PC_out=RESET_PC, fetch_valid=0, flush=0, misalign_trap=0, trap_pc=0, counter=0, state=RUN.
REQ-030 After rst deasserts, fetch_valid SHALL go to 1 at the first rising clk edge, with PC_out=RESET_PC, and PC_out SHALL increment from the next edge.
REQ-031 rst asserted mid-FLUSH or mid-TRAP SHALL abandon the operation immediately with no residual flush or trap.

Configuration
REQ-032 The misalignment check of REQ-024..REQ-028 SHALL be compiled in only when PC_SEQ_ALIGN_CHECK_EN is defined.
REQ-033 When PC_SEQ_ALIGN_CHECK_EN is undefined: misaligned targets redirect as in REQ-017 unmodified, TRAP is unreachable, misalign_trap is tied 0 and trap_pc is tied 0.

Verification
REQ-034 Scenario: reset release, no stall for 4 cycles -> PC_out 0,4,8,12 with fetch_valid=1.
REQ-035 Scenario: at PC 0x10, branch_valid=1, taken=1, PC_branch=0x100, stall=1 -> next PC_out=0x100, flush=1 and fetch_valid=0 for 2 cycles, then 0x104.
REQ-036 Scenario: PC_out=0xFFFF_FFFC, no stall -> next PC_out=0x0000_0000.
REQ-037 Scenario: ALIGN_CHECK on, taken target 0x102 -> misalign_trap=1, trap_pc=0x102, PC held until trap_ack; then PC_out=RESET_PC, 2 flush cycles, then RUN.
REQ-038 Scenario: ALIGN_CHECK off, taken target 0x102 -> PC_out=0x102, misalign_trap stays 0.
REQ-039 Scenario: rst pulsed during the first FLUSH cycle -> outputs at reset values immediately, normal restart from RESET_PC.
